// File: rtl/clogb2.svh
// Ceiling-log2 helper shared by the arbiter: the number of bits needed to
// hold the value passed in (clogb2(7) = 3, clogb2(3) = 2).
`ifndef CLOGB2_SVH
`define CLOGB2_SVH
function automatic integer clogb2(input integer value);
    integer v;
    integer r;
    v = value;
    r = 0;
    while (v > 0) begin
        r = r + 1;
        v = v >> 1;
    end
    return r;
endfunction
`endif

// File: rtl/ram_rr_arbiter_rr_pick.sv
// Rotating priority search: returns the first set bit of req at or above
// start, wrapping modulo N. Purely combinational.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // start + k reduced modulo N (N need not be a power of two)
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return IDX_W'(s);
    endfunction

    // Walk upward from start and latch the first requester found
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[wrap_add(start, k)]) begin
                found = 1'b1;
                index = wrap_add(start, k);
            end
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one write-first block RAM port between REQ_N
// requesters, with optional bounded burst locking. Read data returns one
// cycle after the grant, tagged by a one-hot rsp_valid.
`include "clogb2.svh"

module ram_rr_arbiter #(
    parameter int REQ_N     = 4,
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 8,
    parameter int MAX_BURST = 4,
    localparam int ADDR_W   = clogb2(RAM_DEPTH - 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REQ_N-1:0]            req_valid,
    input  logic [REQ_N-1:0]            req_we,
    input  logic [REQ_N-1:0]            req_lock,
    input  logic [REQ_N*ADDR_W-1:0]     req_addr,
    input  logic [REQ_N*RAM_WIDTH-1:0]  req_din,
    output logic [REQ_N-1:0]            req_ready,
    output logic [REQ_N-1:0]            rsp_valid,
    output logic [RAM_WIDTH-1:0]        rsp_data,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [RAM_WIDTH-1:0]        ram_din,
    input  logic [RAM_WIDTH-1:0]        ram_dout
);

    localparam int             IDX_W      = (REQ_N > 1) ? clogb2(REQ_N - 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQ_N - 1);
    localparam logic [7:0]     BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [REQ_N-1:0]  rsp_q, rsp_d;

    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              grant;
    logic              grant_we;
    logic              grant_lock;
    logic [7:0]        run_cnt;

    // Next requester index after i, wrapping at REQ_N-1
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    // While locked, searching from the owner lets a still-valid owner win
    // outright; if it dropped valid the search falls through to owner+1.
    assign start_idx = (state_q == LOCKED) ? owner_q : ptr_q;

    rr_pick #(
        .N     (REQ_N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .start (start_idx),
        .found (pick_found),
        .index (pick_idx)
    );

    assign grant      = pick_found && !rst;
    assign grant_we   = req_we[pick_idx];
    assign grant_lock = req_lock[pick_idx];

    // Grants already given back-to-back to this requester before this one
    assign run_cnt = (state_q == LOCKED && pick_idx == owner_q) ? cnt_q : 8'd0;

    // State register: arbiter state, pointer, burst tracking, read tag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    // Next-state: enter/extend a burst on a locked grant, otherwise rotate
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (grant) begin
            if (grant_lock && run_cnt < BURST_LAST) begin
                state_d = LOCKED;
                owner_d = pick_idx;
                cnt_d   = run_cnt + 8'd1;
            end else begin
                state_d = ARB;
                ptr_d   = wrap_inc(pick_idx);
                cnt_d   = '0;
            end
        end else if (state_q == LOCKED) begin
            state_d = ARB;
            ptr_d   = wrap_inc(owner_q);
            cnt_d   = '0;
        end
    end

    // Outputs: one-hot ready, RAM port mux, and the read tag for next cycle
    always_comb begin
        req_ready = '0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        rsp_d     = '0;
        if (grant) begin
            ram_en = 1'b1;
            ram_we = grant_we;
            for (int i = 0; i < REQ_N; i++) begin
                if (pick_idx == IDX_W'(i)) begin
                    req_ready[i] = 1'b1;
                    ram_addr     = req_addr[i*ADDR_W +: ADDR_W];
                    ram_din      = req_din[i*RAM_WIDTH +: RAM_WIDTH];
                    rsp_d[i]     = !grant_we;
                end
            end
        end
    end

    // A read in flight when reset arrives is suppressed immediately
    assign rsp_valid = rst ? '0 : rsp_q;
    assign rsp_data  = ram_dout;

endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 Parameter REQ_N, default 4: number of requesters sharing one RAM port (2..16).
REQ-002 Parameter RAM_WIDTH, default 16: data width in bits.
REQ-003 Parameter RAM_DEPTH, default 8: word count. ADDR_W = clogb2(RAM_DEPTH-1).
REQ-004 Parameter MAX_BURST, default 4: maximum number of consecutive locked grants to one requester (1..255).
REQ-005 Port clk, input, 1: the single clock; all logic SHALL be posedge clk.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port req_valid, input, REQ_N: per-requester access request.
REQ-008 Port req_we, input, REQ_N: per-requester write (1) or read (0).
REQ-009 Port req_lock, input, REQ_N: per-requester burst hold request.
REQ-010 Port req_addr, input, REQ_N*ADDR_W: packed addresses; requester i occupies slice i.
REQ-011 Port req_din, input, REQ_N*RAM_WIDTH: packed write data.
REQ-012 Port req_ready, output, REQ_N: one-hot or zero grant for the current cycle.
REQ-013 Port rsp_valid, output, REQ_N: one-hot read-data-valid.
REQ-014 Port rsp_data, output, RAM_WIDTH: read data shared by all requesters.
REQ-015 Ports ram_en/ram_we (1), ram_addr (ADDR_W), ram_din (RAM_WIDTH) outputs; ram_dout (RAM_WIDTH) input: one port of the write-first block RAM, 1-cycle registered read latency.

Function
REQ-016 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-017 req_ready SHALL be combinational from req_valid and the arbiter state, with at most one bit set.
REQ-018 req_ready[i] SHALL NOT depend on req_ready; requesters may hold valid until ready, and must hold addr/we/din stable while waiting.
REQ-019 Round-robin: the search SHALL start at index ptr and go upward modulo REQ_N; the first valid requester is granted.
REQ-020 After an unlocked grant to i, ptr SHALL become (i+1) mod REQ_N; with no grant, ptr SHALL hold.
REQ-021 Lock: if the granted requester i has req_lock[i]=1 and burst_cnt < MAX_BURST-1, the next cycle SHALL grant i again if req_valid[i]=1, regardless of others; burst_cnt increments.
REQ-022 When burst_cnt reaches MAX_BURST-1, or the locked requester drops valid or lock, the lock SHALL release, ptr SHALL become i+1, and burst_cnt SHALL clear.
REQ-023 State machine: ARB (normal round-robin) and LOCKED (holding owner index); ARB->LOCKED on a grant with lock=1 and MAX_BURST>1; LOCKED->ARB per REQ-022.
REQ-024 In a grant cycle: ram_en=1, ram_we=req_we[i], ram_addr/ram_din = slice i. Otherwise ram_en=0, ram_we=0.
REQ-025 A granted read SHALL produce rsp_valid[i]=1 exactly one cycle later, with rsp_data=ram_dout.
REQ-026 Granted writes SHALL produce no rsp_valid.
REQ-027 Back-to-back grants SHALL give full throughput: one access per cycle, no bubbles.
REQ-028 rsp_data SHALL be passed through from ram_dout; it is valid only when any rsp_valid is set.
REQ-029 Wrap: ptr=REQ_N-1 with a grant to REQ_N-1 SHALL give ptr=0.

Reset
REQ-030 In any cycle with rst=1: ptr=0, state=ARB, burst_cnt=0, owner=0, rsp_valid=0, req_ready=0, ram_en=0, ram_we=0.
REQ-031 A read granted in the cycle before rst asserts SHALL NOT produce rsp_valid.
REQ-032 After rst deasserts, requester 0 SHALL have the highest priority.

Structure
REQ-033 No shared package; clogb2 SHALL come from the common clogb2.svh include.
REQ-034 One combinational sub-module, rr_pick (inputs: request vector, start index; outputs: found, index), SHALL implement the rotating search.
REQ-035 The RAM SHALL NOT be instantiated inside this block.

Verification
REQ-036 rst pulse, all valid=1 for 5 cycles -> grants 0,1,2,3,0; after reset ptr=0.
REQ-037 Only requester 2 reads addr 5 (RAM holds 0xBEEF) -> ready[2] in cycle T; rsp_valid=4'b0100 and rsp_data=0xBEEF in T+1.
REQ-038 Requester 1 writes 0x1234 to addr 3, then requester 3 reads addr 3 in the next cycle -> rsp_data=0x1234, and no rsp_valid for the write.
REQ-039 MAX_BURST=4, requester 0 holds lock=1, all valid=1 -> grants 0,0,0,0,1,2,3,0.
REQ-040 Read granted to requester 1, rst asserted the next cycle -> rsp_valid stays 0; after release, requester 0 is granted first.
REQ-041 Random valid/we/lock traffic for 10k cycles against a memory model -> at most one ready per cycle, no requester starved for more than REQ_N*MAX_BURST cycles, all read data matches the model.
